// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
// Time-multiplexed multi-digit hex 7-segment driver. Each digit owns a slot of
// CLK_DIV clocks: the first BLANK_CYCLES are a guard with every digit dark, the
// rest drive the selected digit. Display data is double-buffered: loads go to
// a pending copy that is promoted to the active copy once per frame, so a whole
// frame is always drawn from one snapshot. All outputs are registered and are
// computed from the next-cycle state so segments and digit enables change on
// the same edge.

module seg7_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [4*NUM_DIGITS-1:0]   bin_data,
    input  logic                      load_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      lz_blank_in,
    output logic [6:0]                o_seg,
    output logic [NUM_DIGITS-1:0]     o_dig,
    output logic                      o_frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Pin-level "nothing lit" / "no digit selected" values after polarity.
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // Scan sequencing
    state_t                  state_reg;
    state_t                  state_next;
    logic [CW-1:0]           cnt_reg;
    logic [CW-1:0]           cnt_next;
    logic [IW-1:0]           idx_reg;
    logic [IW-1:0]           idx_next;
    logic                    cnt_wrap;
    logic                    idx_last;
    logic                    frame_start;

    // Double-buffered display data
    logic [4*NUM_DIGITS-1:0] pend_data_reg;
    logic [NUM_DIGITS-1:0]   pend_mask_reg;
    logic                    pend_lz_reg;
    logic [4*NUM_DIGITS-1:0] act_data_reg;
    logic [NUM_DIGITS-1:0]   act_mask_reg;
    logic                    act_lz_reg;
    logic [4*NUM_DIGITS-1:0] act_data_next;
    logic [NUM_DIGITS-1:0]   act_mask_next;
    logic                    act_lz_next;

    // Output datapath
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [3:0]              nibble;
    logic [6:0]              seg_raw;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   dig_next;
    logic                    frame_done_next;

    // Hex to active-high segment pattern, bit6 = A ... bit0 = G.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    // Next slot position, guard/on phase and frame-start promotion of pending data.
    always_comb begin
        cnt_wrap    = (cnt_reg == CNT_LAST);
        idx_last    = (idx_reg == IDX_LAST);
        frame_start = (idx_reg == '0) && (cnt_reg == '0);

        cnt_next = cnt_wrap ? '0 : cnt_reg + 1'b1;
        if (cnt_wrap) begin
            idx_next = idx_last ? '0 : idx_reg + 1'b1;
        end else begin
            idx_next = idx_reg;
        end

        state_next = state_reg;
        case (state_reg)
            ST_GUARD: if (cnt_reg == GUARD_LAST) state_next = ST_ON;
            ST_ON:    if (cnt_wrap)              state_next = ST_GUARD;
            default:                             state_next = ST_GUARD;
        endcase

        // The active copy used by the rest of the frame is the pending copy
        // as it stood before this cycle's load, so a load landing exactly on
        // the frame-start cycle waits for the following frame.
        if (frame_start) begin
            act_data_next = pend_data_reg;
            act_mask_next = pend_mask_reg;
            act_lz_next   = pend_lz_reg;
        end else begin
            act_data_next = act_data_reg;
            act_mask_next = act_mask_reg;
            act_lz_next   = act_lz_reg;
        end

        frame_done_next = cnt_wrap && idx_last;
    end

    // Per-digit darkening: explicit mask, or leading zero above digit 0.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank_vec[gi] = act_mask_next[gi];
            end else begin : g_upper
                assign blank_vec[gi] = act_mask_next[gi] |
                    (act_lz_next & (act_data_next[4*NUM_DIGITS-1:4*gi] == '0));
            end
        end
    endgenerate

    // Segment and digit-enable values for the upcoming cycle, polarity applied.
    always_comb begin
        nibble  = act_data_next[{idx_next, 2'b00} +: 4];
        seg_raw = 7'h00;
        if ((state_next == ST_ON) && !blank_vec[idx_next]) begin
            seg_raw = hex_to_seg(nibble);
        end
        seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;

        dig_next = '0;
        if (state_next == ST_ON) begin
            dig_next = NUM_DIGITS'(1) << idx_next;
        end
        if (DIG_ACTIVE_LOW != 0) begin
            dig_next = ~dig_next;
        end
    end

    // Scan FSM with registered pin outputs; reset darkens the display at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= ST_GUARD;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            o_seg        <= SEG_OFF;
            o_dig        <= DIG_OFF;
            o_frame_done <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            o_seg        <= seg_next;
            o_dig        <= dig_next;
            o_frame_done <= frame_done_next;
        end
    end

    // Pending capture on load and once-per-frame promotion to the active copy.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pend_data_reg <= '0;
            pend_mask_reg <= '0;
            pend_lz_reg   <= 1'b0;
            act_data_reg  <= '0;
            act_mask_reg  <= '0;
            act_lz_reg    <= 1'b0;
        end else begin
            if (load_in) begin
                pend_data_reg <= bin_data;
                pend_mask_reg <= blank_mask;
                pend_lz_reg   <= lz_blank_in;
            end
            act_data_reg <= act_data_next;
            act_mask_reg <= act_mask_next;
            act_lz_reg   <= act_lz_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux
// Directed plus random stimulus for a 4-digit, 8-clock-slot scanner. The
// reference model works from the cycle number since reset release: it derives
// frame, digit and slot position arithmetically and picks the data snapshot as
// the last load issued strictly before that frame's first cycle.

module tb_seg7_scan_mux;

    localparam int ND    = 4;
    localparam int CD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * CD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bin_data = '0;
    logic        load_in = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic        lz_blank_in = 1'b0;
    logic [6:0]  o_seg;
    logic [3:0]  o_dig;
    logic        o_frame_done;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .NUM_DIGITS(ND),
        .CLK_DIV(CD),
        .BLANK_CYCLES(BC),
        .SEG_ACTIVE_LOW(0),
        .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .bin_data(bin_data),
        .load_in(load_in),
        .blank_mask(blank_mask),
        .lz_blank_in(lz_blank_in),
        .o_seg(o_seg),
        .o_dig(o_dig),
        .o_frame_done(o_frame_done)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [3:0]  mask;
        bit          lz;
    } load_t;

    load_t      loads[$];
    int         checks = 0;
    int         failures = 0;
    int         t = 0;
    logic [6:0] enc [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
        end
    endtask

    // Display must be fully dark while reset is held.
    task automatic check_reset(input string tag);
        check({tag, "_dig"}, 32'(o_dig), 32'h0000000F);
        check({tag, "_seg"}, 32'(o_seg), 32'h00000000);
        check({tag, "_fd"},  32'(o_frame_done), 32'h00000000);
    endtask

    // Compare all outputs against the model for cycle t.
    task automatic check_cycle();
        int          k;
        int          pos;
        int          d;
        int          c;
        logic [15:0] sd;
        logic [3:0]  sm;
        bit          sl;
        logic [15:0] up;
        logic [6:0]  es;
        logic [3:0]  ed;
        k   = t / FRAME;
        pos = t % FRAME;
        d   = pos / CD;
        c   = pos % CD;
        sd  = '0;
        sm  = '0;
        sl  = 1'b0;
        foreach (loads[i]) begin
            if (loads[i].cyc < FRAME * k) begin
                sd = loads[i].data;
                sm = loads[i].mask;
                sl = loads[i].lz;
            end
        end
        up = sd >> (4 * d);
        if (c < BC) begin
            ed = 4'hF;
            es = 7'h00;
        end else begin
            ed = ~(4'b0001 << d);
            if (sm[d] || (sl && d > 0 && up == 16'h0000)) es = 7'h00;
            else es = enc[up[3:0]];
        end
        check("dig", 32'(o_dig), 32'(ed));
        check("seg", 32'(o_seg), 32'(es));
        check("frame_done", 32'(o_frame_done), (t > 0 && pos == 0) ? 32'd1 : 32'd0);
    endtask

    // One clock: check current cycle, drive inputs sampled at its closing edge.
    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] m, input bit lz);
        load_t e;
        check_cycle();
        load_in     = ld;
        bin_data    = d;
        blank_mask  = m;
        lz_blank_in = lz;
        if (ld) begin
            e.cyc  = t;
            e.data = d;
            e.mask = m;
            e.lz   = lz;
            loads.push_back(e);
        end
        @(negedge clk);
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) step(1'b0, 16'h0000, 4'h0, 1'b0);
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rm;

        // Reset held, then released on a falling edge; cycle 0 starts there.
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        t = 0;

        // Default frames, then a mid-frame load that must wait one frame.
        run_to(40);
        step(1'b1, 16'h12AF, 4'h0, 1'b0);
        // Leading-zero suppression: single digit, then all-zero value.
        run_to(100);
        step(1'b1, 16'h0007, 4'h0, 1'b1);
        run_to(170);
        step(1'b1, 16'h0000, 4'h0, 1'b1);
        // Explicit mask on digits 0 and 2.
        run_to(230);
        step(1'b1, 16'h8888, 4'b0101, 1'b0);
        // Two loads in one frame: the second one is shown.
        run_to(290);
        step(1'b1, 16'h1111, 4'h0, 1'b0);
        run_to(300);
        step(1'b1, 16'h2222, 4'h0, 1'b0);
        // Load on the exact frame-start cycle is deferred one frame.
        run_to(11 * FRAME);
        step(1'b1, 16'h3333, 4'h0, 1'b0);
        run_to(13 * FRAME + 5);

        // Random loads with varied leading zeros, masks and suppression.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                rd = 16'($urandom) >> (4 * $urandom_range(0, 4));
                rm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                step(1'b1, rd, rm, 1'($urandom));
            end else begin
                step(1'b0, 16'h0000, 4'h0, 1'b0);
            end
        end

        // Pending load that reset must discard, then reset mid digit-2 ON.
        while ((t % FRAME) != 10) step(1'b0, 16'h0000, 4'h0, 1'b0);
        step(1'b1, 16'h5A5A, 4'h0, 1'b0);
        while ((t % FRAME) != 2 * CD + 3) step(1'b0, 16'h0000, 4'h0, 1'b0);
        check_cycle();
        load_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (2) begin
            @(negedge clk);
            check_reset("reset_hold");
        end
        rst_n = 1'b1;
        loads.delete();
        t = 0;
        run_to(2 * FRAME + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
